// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, memory address selects,
// ALU operand selects and the decoded-instruction record. IRQ state exists only with CPU_IRQ_EN.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_RIMM   = 3'd2,
    ST_RADDR  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
`ifdef CPU_IRQ_EN
    , ST_IRQ  = 3'd6
`endif
  } state_t;

  localparam logic [1:0] MA_PC  = 2'd0;
  localparam logic [1:0] MA_A   = 2'd1;
  localparam logic [1:0] MA_VEC = 2'd2;

  // Register selects REG0..REG3 are REG0 plus the register index.
  localparam logic [2:0] ALU1_REG0 = 3'b000;
  localparam logic [2:0] ALU1_MEM  = 3'b100;
  localparam logic [2:0] ALU1_PC   = 3'b101;
  localparam logic [2:0] ALU2_REG0 = 3'b000;
  localparam logic [2:0] ALU2_OP   = 3'b100;
  localparam logic [2:0] ALU2_ONE  = 3'b101;

  localparam logic [2:0] DEST_MEM = 3'b111;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_ADDR = 2'd2,
    SRC_BAD  = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    DK_REG = 2'd0,
    DK_MEM = 2'd1,
    DK_BAD = 2'd2
  } dest_kind_t;

  typedef struct packed {
    src_t       src;
    logic [3:0] func;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    dest_kind_t dkind;
    logic [1:0] dest_idx;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: splits the low 16 opcode bits into source mode,
// ALU controls and destination. Class/source faults go to illegal; destination faults to dkind.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int REG_CNT = 3
) (
  input  logic [15:0] i_opcode,
  output dec_t        o_dec
);

  localparam logic [2:0] LP_REG_CNT = 3'(REG_CNT);

  logic [2:0] w_s1;
  logic       w_is_a;
  logic       w_is_i;

  assign w_s1   = i_opcode[11:9];
  assign w_is_a = (i_opcode[15:12] == 4'b0000);
  assign w_is_i = (i_opcode[15:14] == 2'b01);

  always_comb begin
    // NOTE: every field gets a default before any branch, so no path can infer a latch.
    o_dec.src      = SRC_BAD;
    o_dec.func     = 4'd0;
    o_dec.alu_a    = w_s1[2] ? ALU1_MEM : (ALU1_REG0 + {1'b0, w_s1[1:0]});
    o_dec.alu_b    = ALU2_REG0;
    o_dec.dkind    = DK_BAD;
    o_dec.dest_idx = 2'd0;

    if (!w_s1[2])               o_dec.src = SRC_REG;
    else if (w_s1 == 3'b100)    o_dec.src = SRC_IMM;
    else if (w_s1 == 3'b110)    o_dec.src = SRC_ADDR;

    if (w_is_a) begin
      o_dec.alu_b    = ALU2_REG0 + {1'b0, i_opcode[4:3]};
      o_dec.func     = i_opcode[8:5];
      o_dec.dest_idx = i_opcode[1:0];
      if (i_opcode[2:0] == DEST_MEM)        o_dec.dkind = DK_MEM;
      else if (i_opcode[2:0] < LP_REG_CNT)  o_dec.dkind = DK_REG;
    end else if (w_is_i) begin
      o_dec.alu_b    = ALU2_OP;
      o_dec.func     = {i_opcode[8], i_opcode[8], i_opcode[13:12]};
      o_dec.dest_idx = w_s1[1:0];
      if ({1'b0, w_s1[1:0]} < LP_REG_CNT)   o_dec.dkind = DK_REG;
    end

    o_dec.illegal = !(w_is_a || w_is_i) || (o_dec.src == SRC_BAD);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control FSM with req/ack memory handshake, DECODE cycle and sticky illegal flag.
// Optional interrupt vectoring (irq/irq_ack ports, IRQ state) is built when CPU_IRQ_EN is defined.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W   = 16,
  parameter int REG_CNT    = 3,
  parameter int ALU_FUNC_W = 4,
  parameter int RESET_HALT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [OPCODE_W-1:0]   i_opcode,
  input  logic                  i_mem_ack,
`ifdef CPU_IRQ_EN
  input  logic                  i_irq,
  output logic                  o_irq_ack,
`endif
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [1:0]            o_mem_addr_sel,
  output logic                  o_en_pc,
  output logic                  o_save_opcode,
  output logic                  o_save_mem,
  output logic [ALU_FUNC_W-1:0] o_alu_func,
  output logic [2:0]            o_alu_a,
  output logic [2:0]            o_alu_b,
  output logic [REG_CNT-1:0]    o_en_reg,
  output logic                  o_halted,
  output logic                  o_illegal
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_illegal_next;
  logic   w_irq_take;
  dec_t   w_dec;

  cpu_decode #(.REG_CNT(REG_CNT)) u_decode (
    .i_opcode (i_opcode[15:0]),
    .o_dec    (w_dec)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= (RESET_HALT != 0) ? ST_HALT : ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal_next;
    end
  end

`ifdef CPU_IRQ_EN
  // Entry flag is not raised on return from IRQ, so one irq level vectors only once.
  logic r_fetch_entry;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fetch_entry <= 1'b1;
    else     r_fetch_entry <= (w_next == ST_FETCH) && (r_state != ST_FETCH) && (r_state != ST_IRQ);
  end
  assign w_irq_take = r_fetch_entry & i_irq;
`else
  assign w_irq_take = 1'b0;
`endif

  assign o_illegal = r_illegal;

  always_comb begin
    w_next         = r_state;
    w_illegal_next = r_illegal;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = MA_PC;
    o_en_pc        = 1'b0;
    o_save_opcode  = 1'b0;
    o_save_mem     = 1'b0;
    o_alu_func     = '0;
    o_alu_a        = 3'd0;
    o_alu_b        = 3'd0;
    o_en_reg       = '0;
    o_halted       = 1'b0;
`ifdef CPU_IRQ_EN
    o_irq_ack      = 1'b0;
`endif

    // Outputs track rst combinationally so a dropped request disappears in the same cycle.
    if (rst) begin
      o_halted = (RESET_HALT != 0);
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_irq_take) begin
`ifdef CPU_IRQ_EN
            w_next = ST_IRQ;
`endif
          end else begin
            o_mem_req = 1'b1;
            o_alu_a   = ALU1_PC;
            o_alu_b   = ALU2_ONE;
            if (i_mem_ack) begin
              o_save_opcode = 1'b1;
              o_en_pc       = 1'b1;
              w_next        = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          if (w_dec.illegal) begin
            w_next         = ST_HALT;
            w_illegal_next = 1'b1;
          end else begin
            case (w_dec.src)
              SRC_IMM:  w_next = ST_RIMM;
              SRC_ADDR: w_next = ST_RADDR;
              default:  w_next = ST_EXEC;
            endcase
          end
        end
        ST_RIMM: begin
          o_mem_req = 1'b1;
          o_alu_a   = ALU1_PC;
          o_alu_b   = ALU2_ONE;
          if (i_mem_ack) begin
            o_save_mem = 1'b1;
            o_en_pc    = 1'b1;
            w_next     = ST_EXEC;
          end
        end
        ST_RADDR: begin
          o_mem_req      = 1'b1;
          o_mem_addr_sel = MA_A;
          if (i_mem_ack) begin
            o_save_mem = 1'b1;
            w_next     = ST_EXEC;
          end
        end
        ST_EXEC: begin
          o_alu_a    = w_dec.alu_a;
          o_alu_b    = w_dec.alu_b;
          o_alu_func = ALU_FUNC_W'(w_dec.func);
          case (w_dec.dkind)
            DK_REG: begin
              o_en_reg = REG_CNT'(1) << w_dec.dest_idx;
              w_next   = ST_FETCH;
            end
            DK_MEM: begin
              o_mem_req      = 1'b1;
              o_mem_we       = 1'b1;
              o_mem_addr_sel = MA_A;
              if (i_mem_ack) w_next = ST_FETCH;
            end
            default: begin
              w_next         = ST_HALT;
              w_illegal_next = 1'b1;
            end
          endcase
        end
        ST_HALT: begin
          o_halted = 1'b1;
          if (i_start) begin
            w_next         = ST_FETCH;
            w_illegal_next = 1'b0;
          end
        end
`ifdef CPU_IRQ_EN
        ST_IRQ: begin
          o_mem_req      = 1'b1;
          o_mem_addr_sel = MA_VEC;
          if (i_mem_ack) begin
            o_en_pc   = 1'b1;
            o_irq_ack = 1'b1;
            w_next    = ST_FETCH;
          end
        end
`endif
        default: w_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one step per clock, inputs driven and outputs sampled
// between edges, expected values worked out by hand from the instruction encodings.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_opcode = 16'h0000;
  logic        i_mem_ack = 1'b0;
  logic        o_mem_req, o_mem_we, o_en_pc, o_save_opcode, o_save_mem, o_halted, o_illegal;
  logic [1:0]  o_mem_addr_sel;
  logic [3:0]  o_alu_func;
  logic [2:0]  o_alu_a, o_alu_b, o_en_reg;
`ifdef CPU_IRQ_EN
  logic        i_irq = 1'b0;
  logic        o_irq_ack;
`endif

  cpu_sequencer #(
    .OPCODE_W(16), .REG_CNT(3), .ALU_FUNC_W(4), .RESET_HALT(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_opcode       (i_opcode),
    .i_mem_ack      (i_mem_ack),
`ifdef CPU_IRQ_EN
    .i_irq          (i_irq),
    .o_irq_ack      (o_irq_ack),
`endif
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr_sel (o_mem_addr_sel),
    .o_en_pc        (o_en_pc),
    .o_save_opcode  (o_save_opcode),
    .o_save_mem     (o_save_mem),
    .o_alu_func     (o_alu_func),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .o_en_reg       (o_en_reg),
    .o_halted       (o_halted),
    .o_illegal      (o_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int c_req, c_we, c_pc, c_sop, c_smem, c_reg;

  logic       s_req, s_we, s_pc, s_sop, s_smem, s_halt, s_ill, s_irqack;
  logic [1:0] s_sel;
  logic [3:0] s_func;
  logic [2:0] s_a, s_b, s_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    c_req = 0; c_we = 0; c_pc = 0; c_sop = 0; c_smem = 0; c_reg = 0;
  endtask

  // Drive ack, sample the current state's outputs mid-cycle, then advance one clock.
  task automatic step(input logic ack);
    i_mem_ack = ack;
    #1;
    s_req = o_mem_req; s_we = o_mem_we; s_sel = o_mem_addr_sel; s_pc = o_en_pc;
    s_sop = o_save_opcode; s_smem = o_save_mem; s_func = o_alu_func; s_a = o_alu_a;
    s_b = o_alu_b; s_reg = o_en_reg; s_halt = o_halted; s_ill = o_illegal;
`ifdef CPU_IRQ_EN
    s_irqack = o_irq_ack;
`else
    s_irqack = 1'b0;
`endif
    c_req  += int'(s_req);
    c_we   += int'(s_we);
    c_pc   += int'(s_pc);
    c_sop  += int'(s_sop);
    c_smem += int'(s_smem);
    c_reg  += int'(|s_reg);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #2;
    #1;
    check("rst_outputs", {o_mem_req, o_mem_we, o_mem_addr_sel, o_en_pc, o_save_opcode,
                          o_save_mem, o_alu_func, o_alu_a, o_alu_b, o_en_reg}, 32'd0);
    check("rst_halted_illegal", {o_halted, o_illegal}, 2'b00);
    rst = 1'b0;

    // A-type 0x0001, zero wait: FETCH, DECODE, EXEC en_reg=010
    i_opcode = 16'h0001;
    step(1'b1);
    check("t1_fetch_req_sop_pc", {s_req, s_sop, s_pc}, 3'b111);
    check("t1_fetch_alu", {s_sel, s_a, s_b}, {MA_PC, ALU1_PC, ALU2_ONE});
    step(1'b1);
    check("t1_decode_idle", {s_req, s_pc, s_sop, s_smem, s_reg}, 7'd0);
    step(1'b1);
    check("t1_exec_en_reg", s_reg, 3'b010);
    check("t1_exec_alu", {s_a, s_b, s_func}, {3'd0, 3'd0, 4'd0});

    // Cycle 4 is FETCH again; hold ack low 3 cycles
    clr();
    for (int k = 0; k < 4; k++) begin
      step(k == 3);
      check("t2_req_held", s_req, 1'b1);
      check("t2_sel_stable", s_sel, MA_PC);
    end
    check("t2_req_cycles", c_req, 4);
    check("t2_en_pc_once", c_pc, 1);
    check("t2_save_opcode_once", c_sop, 1);
    step(1'b1);
    step(1'b1);
    check("t2_exec_en_reg", s_reg, 3'b010);

    // RIMM: 0x0870 (s1=100, func=3, b=REG2, dest=0)
    i_opcode = 16'h0870;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("t3_rimm_wait", {s_req, s_sel, s_pc, s_smem, s_sop}, {1'b1, MA_PC, 3'b000});
    step(1'b1);
    check("t3_rimm_ack", {s_pc, s_smem, s_sop}, 3'b110);
    step(1'b1);
    check("t3_exec_alu", {s_a, s_b, s_func}, {ALU1_MEM, 3'd2, 4'd3});
    check("t3_exec_en_reg", s_reg, 3'b001);

    // RADDR: 0x0CAA (s1=110, func=5, b=REG1, dest=2)
    i_opcode = 16'h0CAA;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("t4_raddr_wait", {s_req, s_sel, s_pc, s_smem}, {1'b1, MA_A, 2'b00});
    step(1'b1);
    check("t4_raddr_ack", {s_pc, s_smem}, 2'b01);
    step(1'b1);
    check("t4_exec_alu", {s_a, s_b, s_func}, {ALU1_MEM, 3'd1, 4'd5});
    check("t4_exec_en_reg", s_reg, 3'b100);

    // Bad class 0xF000 -> HALT with illegal
    i_opcode = 16'hF000;
    step(1'b1);
    clr();
    step(1'b1);
    step(1'b0);
    check("t5_halt", {s_halt, s_ill, s_req}, 3'b110);
    check("t5_no_en_reg", c_reg, 0);
    i_start = 1'b1;
    step(1'b0);
    i_start = 1'b0;
    i_opcode = 16'h0A00;
    step(1'b1);
    check("t5_restart_fetch", {s_halt, s_ill, s_req}, 3'b001);

    // s1=101 -> HALT with illegal
    step(1'b1);
    step(1'b0);
    check("t6_halt_s1_101", {s_halt, s_ill}, 2'b11);
    i_start = 1'b1;
    step(1'b0);
    i_start = 1'b0;

    // A-type dest=3 with REG_CNT=3 -> illegal at EXEC, no enable
    i_opcode = 16'h0003;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("t6b_exec_no_en", {s_reg, s_halt}, 4'd0);
    step(1'b0);
    check("t6b_halt", {s_halt, s_ill}, 2'b11);
    i_start = 1'b1;
    step(1'b0);
    i_start = 1'b0;

    // Memory destination 0x0007, ack after 2 wait cycles
    i_opcode = 16'h0007;
    step(1'b1);
    step(1'b1);
    clr();
    for (int k = 0; k < 3; k++) begin
      step(k == 2);
      check("t7_store_req", {s_req, s_sel}, {1'b1, MA_A});
    end
    check("t7_we_cycles", c_we, 3);
    check("t7_no_en_reg", c_reg, 0);
    i_opcode = 16'h6500;
    step(1'b1);
    check("t7_back_fetch", {s_we, s_req, s_sop}, 3'b011);

    // I-type 0x6500: s1=010, func={1,1,10}
    step(1'b1);
    step(1'b1);
    check("t8_itype_alu", {s_a, s_b, s_func}, {3'd2, ALU2_OP, 4'hE});
    check("t8_itype_en_reg", s_reg, 3'b100);

    // I-type dest=3 -> illegal
    i_opcode = 16'h4600;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("t8b_no_en_reg", s_reg, 3'b000);
    step(1'b0);
    check("t8b_halt", {s_halt, s_ill}, 2'b11);
    i_start = 1'b1;
    step(1'b0);
    i_start = 1'b0;

    // rst mid RADDR wait
    i_opcode = 16'h0CAA;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("t9_raddr_pending", {s_req, s_sel}, {1'b1, MA_A});
    i_mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("t9_rst_outputs", {o_mem_req, o_mem_we, o_mem_addr_sel, o_en_pc, o_save_opcode,
                             o_save_mem, o_alu_func, o_alu_a, o_alu_b, o_en_reg,
                             o_halted, o_illegal}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b1);
    check("t9_after_rst_fetch", {s_req, s_sel, s_sop}, {1'b1, MA_PC, 1'b1});

`ifdef CPU_IRQ_EN
    rst = 1'b1;
    i_irq = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b0);
    check("irq_entry_no_req", s_req, 1'b0);
    step(1'b0);
    check("irq_wait", {s_req, s_sel, s_irqack, s_pc}, {1'b1, MA_VEC, 2'b00});
    step(1'b1);
    check("irq_ack", {s_irqack, s_pc}, 2'b11);
    i_irq = 1'b0;
    step(1'b1);
    check("irq_back_fetch", {s_irqack, s_sop, s_sel}, {2'b01, MA_PC});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
